ps2_kbd_sender: RTL and testbench

Device-side PS/2 keyboard transmitter. It serialises scan-code bytes into standard 11-bit PS/2 frames on ps2_clk/ps2_data. The block acts as a keyboard model, driving the board's PS/2 receiver in simulation and in on-board loopback tests. It sits between a scan-code source (test sequencer or key-matrix logic) and the PS/2 pins.

---
 rtl/ps2_kbd_sender.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_kbd_sender.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_sender.sv
// ps2_kbd_sender: device-side PS/2 keyboard transmitter.
// Each scan-code byte is sent as an 11-bit frame on ps2_clk/ps2_data:
// start 0, data LSB first, odd parity, stop 1.
// The serialiser timeline, counted from the accept edge, is:
//   one cycle with the lines still idle,
//   eleven bits of 2*HALF_PERIOD cycles each (high phase, then low phase),
//   then GAP - 1 idle cycles while busy is still asserted.
// This gives a frame-to-frame period of 22*HALF_PERIOD + GAP cycles.
// Optional macro PS2_TX_FIFO_EN places a FIFO_DEPTH-entry byte FIFO in front
// of the serialiser. Without it, one holding register accepts bytes only in IDLE.
module ps2_kbd_sender #(
    parameter int HALF_PERIOD = 50,
    parameter int GAP         = 100,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int CNT_MAX = (HALF_PERIOD > GAP) ? HALF_PERIOD : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [3:0]    LAST_BIT = 4'd10;

    // Reject parameter sets the counters and FIFO pointers cannot represent.
    if (HALF_PERIOD < 2 || GAP < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_paramCheck
        $error("ps2_kbd_sender: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bitIdx_q, bitIdx_d;
    logic [10:0]    frame_q, frame_d;
    logic           ready_q, ready_d;
    logic           busy_q;
    logic           ps2Clk_q;
    logic           ps2Data_q;

    logic           accept;
    logic           haveByte;
    logic [7:0]     nextByte;
    logic           load;

    assign accept   = valid && ready_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign ps2_clk  = ps2Clk_q;
    assign ps2_data = ps2Data_q;

`ifdef PS2_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]     fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0]  rdPtr_q, wrPtr_q;
    logic [AW:0]    count_q, count_d;
    logic           fifoEmpty;
    logic           push;
    logic           pop;

    // When the FIFO is empty, an accepted byte goes straight to the serialiser.
    // This keeps the latency from accept to start bit the same as the plain build.
    assign fifoEmpty = (count_q == '0);
    assign haveByte  = !fifoEmpty || accept;
    assign nextByte  = fifoEmpty ? data : fifoMem_q[rdPtr_q];
    assign pop       = load && !fifoEmpty;
    assign push      = accept && !(load && fifoEmpty);
    assign ready_d   = (count_d != FULL_COUNT);

    // Occupancy after this edge's push and pop; ready is derived from it.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifoMem_q[wrPtr_q] <= data;
                wrPtr_q            <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end
`else
    assign haveByte = accept;
    assign nextByte = data;
    assign ready_d  = (state_d == S_IDLE);
`endif

    // Next state of the frame sequencer. A new frame is loaded from IDLE,
    // or directly at the end of a gap when another byte is already waiting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        frame_d  = frame_q;
        load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (haveByte) begin
                    load = 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q == HP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOW: begin
                if (cnt_q == HP_LAST) begin
                    cnt_d = '0;
                    if (bitIdx_q == LAST_BIT) begin
                        state_d = S_GAP;
                    end else begin
                        bitIdx_d = bitIdx_q + 4'd1;
                        state_d  = S_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (haveByte) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (load) begin
            state_d  = S_HIGH;
            cnt_d    = '0;
            bitIdx_d = '0;
            frame_d  = {1'b1, ~^nextByte, nextByte, 1'b0};
        end
    end

    // Sequencer registers and registered outputs. The line outputs follow the
    // previous state, so the start bit appears one edge after the accept.
    // Reset forces both lines high at once.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bitIdx_q  <= '0;
            frame_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            ps2Clk_q  <= 1'b1;
            ps2Data_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitIdx_q  <= bitIdx_d;
            frame_q   <= frame_d;
            ready_q   <= ready_d;
            busy_q    <= (state_d != S_IDLE);
            ps2Clk_q  <= (state_q != S_LOW);
            ps2Data_q <= (state_q == S_HIGH || state_q == S_LOW) ? frame_q[bitIdx_q] : 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_sender.sv
// Testbench for ps2_kbd_sender.
// A timeline model predicts ready, busy and both PS/2 lines every cycle from
// the frame rules. A falling-edge decoder recovers the bytes from the lines.
module tb_ps2_kbd_sender;

    localparam int HP    = 4;
    localparam int GAPC  = 6;
    localparam int DEPTH = 4;
    localparam int FRAME = 22 * HP + GAPC;

    logic       clk   = 1'b0;
    logic       clrn  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       busy;
    logic       ps2_clk;
    logic       ps2_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ps2_kbd_sender #(
        .HALF_PERIOD(HP),
        .GAP        (GAPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .clrn    (clrn),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data)
    );

    // Free-running system clock and edge counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model.
    // mT is the number of edges since the current frame was accepted.
    // Pending bytes wait in mQ; mDone lists frames that ran to completion.
    bit         mActive = 0;
    int         mT      = 0;
    logic [7:0] mCur    = 8'h00;
    logic [7:0] mQ[$];
    logic [7:0] mDone[$];
    logic       eReady  = 1'b0;
    logic       eBusy   = 1'b0;
    logic       eClk    = 1'b1;
    logic       eData   = 1'b1;

    function automatic logic frameBit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9) return ~^b;
        return 1'b1;
    endfunction

    // Advance the model timeline at each edge, or clear it on reset.
    always @(posedge clk or negedge clrn) begin : modelProc
        bit acc;
        bit used;
        int k;
        int ph;
        if (!clrn) begin
            mActive = 0;
            mT      = 0;
            mQ.delete();
            eReady  = 1'b0;
            eBusy   = 1'b0;
            eClk    = 1'b1;
            eData   = 1'b1;
        end else begin
            acc  = valid && eReady;
            used = 0;
            if (mActive) begin
                mT++;
                if (mT == FRAME) begin
                    mDone.push_back(mCur);
                    if (mQ.size() > 0) begin
                        mCur = mQ.pop_front();
                        mT   = 0;
                    end else if (acc) begin
                        mCur = data;
                        mT   = 0;
                        used = 1;
                    end else begin
                        mActive = 0;
                    end
                end
            end else if (acc) begin
                mActive = 1;
                mCur    = data;
                mT      = 0;
                used    = 1;
            end
            if (acc && !used) mQ.push_back(data);
            eBusy = mActive;
            if (mActive && mT >= 1 && mT <= 22 * HP) begin
                k     = (mT - 1) / (2 * HP);
                ph    = (mT - 1) % (2 * HP);
                eClk  = (ph < HP);
                eData = frameBit(mCur, k);
            end else begin
                eClk  = 1'b1;
                eData = 1'b1;
            end
`ifdef PS2_TX_FIFO_EN
            eReady = (mQ.size() < DEPTH);
`else
            eReady = !mActive;
`endif
        end
    end

    // Compare every DUT output with the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("ready", ready, eReady);
        checkOutput("busy", busy, eBusy);
        checkOutput("ps2_clk", ps2_clk, eClk);
        checkOutput("ps2_data", ps2_data, eData);
    end

    // Receiver-side decoder: sample ps2_data at each ps2_clk fall.
    logic        prevClk = 1'b1;
    int          nBits   = 0;
    logic [10:0] shf     = '0;
    logic [10:0] rxFrames[$];
    int          fallCyc[$];

    always @(negedge clk) begin
        if (!clrn) begin
            nBits   = 0;
            prevClk = 1'b1;
        end else begin
            if (prevClk && !ps2_clk) begin
                shf[nBits] = ps2_data;
                nBits++;
                fallCyc.push_back(cyc);
                if (nBits == 11) begin
                    rxFrames.push_back(shf);
                    nBits = 0;
                end
            end
            prevClk = ps2_clk;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, output int accCyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) checkOutput("readyTimeout", 0, 1);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        accCyc = cyc;
        valid  = 1'b0;
    endtask

    task automatic waitIdle(output int dropCyc);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (busy && guard < 3000);
        if (guard >= 3000) checkOutput("idleTimeout", 0, 1);
        dropCyc = cyc;
    endtask

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int acc;
        int acc2;
        int drop;
        int base;
        int nRx;
        int guard;
        int pushed;

        repeat (3) @(negedge clk);
        checkOutput("resetReady", ready, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetClk", ps2_clk, 1);
        checkOutput("resetData", ps2_data, 1);
        clrn = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterReset", ready, 1);

        // 0x1C: bits, first-fall latency and busy length.
        base = fallCyc.size();
        applyStimulus(8'h1C, acc);
        waitIdle(drop);
        checkOutput("firstFallLatency", fallCyc[base] - acc, HP + 1);
        checkOutput("busyLength", drop - acc, 22 * HP + GAPC);
        checkOutput("frame1C", rxFrames[rxFrames.size()-1], 11'h438);

        // Parity of 0x01, 0x00 and 0xFF; frames are sent back to back.
        base = fallCyc.size();
        nRx  = rxFrames.size();
        applyStimulus(8'h01, acc);
        applyStimulus(8'h00, acc);
        applyStimulus(8'hFF, acc);
        waitIdle(drop);
        checkOutput("parity01", rxFrames[nRx][9], 0);
        checkOutput("parity00", rxFrames[nRx+1][9], 1);
        checkOutput("parityFF", rxFrames[nRx+2][9], 1);
        checkOutput("stopFF", rxFrames[nRx+2][10], 1);
        checkOutput("gapAtLeast", (fallCyc[base+11] - fallCyc[base]) >= FRAME, 1);

`ifndef PS2_TX_FIFO_EN
        // A byte offered while busy must be ignored.
        nRx = rxFrames.size();
        applyStimulus(8'h33, acc);
        repeat (5) @(negedge clk);
        valid = 1'b1;
        data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            checkOutput("readyWhileBusy", ready, 0);
        end
        valid = 1'b0;
        waitIdle(drop);
        repeat (HP * 4) @(negedge clk);
        checkOutput("onlyOneFrame", rxFrames.size(), nRx + 1);
        checkOutput("frame33", rxFrames[nRx][8:1], 8'h33);
`else
        // Three consecutive pushes; frames leave at the exact frame period.
        base = fallCyc.size();
        nRx  = rxFrames.size();
        @(negedge clk);
        valid = 1'b1;
        data  = 8'hF0;
        @(negedge clk);
        acc = cyc;
        checkOutput("readyPush1", ready, 1);
        data = 8'h1C;
        @(negedge clk);
        checkOutput("readyPush2", ready, 1);
        data = 8'h12;
        @(negedge clk);
        valid = 1'b0;
        waitIdle(drop);
        checkOutput("fifoFirstFall", fallCyc[base] - acc, HP + 1);
        checkOutput("fifoPeriod1", fallCyc[base+11] - fallCyc[base], FRAME);
        checkOutput("fifoPeriod2", fallCyc[base+22] - fallCyc[base+11], FRAME);
        checkOutput("fifoOrder0", rxFrames[nRx][8:1], 8'hF0);
        checkOutput("fifoOrder1", rxFrames[nRx+1][8:1], 8'h1C);
        checkOutput("fifoOrder2", rxFrames[nRx+2][8:1], 8'h12);

        // DEPTH+1 pushes during one frame fill the FIFO.
        pushed = 0;
        guard  = 0;
        @(negedge clk);
        while (pushed < DEPTH + 1 && guard < 100) begin
            valid = 1'b1;
            data  = 8'($urandom);
            @(negedge clk);
            pushed++;
            guard++;
        end
        valid = 1'b0;
        checkOutput("fifoFull", ready, 0);
        waitIdle(drop);
`endif

        // Reset at the 5th fall of 0xAA, then 0x3C must go out cleanly.
        applyStimulus(8'hAA, acc);
        guard = 0;
        while (nBits != 5 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reachFall5", nBits, 5);
        #2;
        clrn = 1'b0;
        #1;
        checkOutput("abortClk", ps2_clk, 1);
        checkOutput("abortData", ps2_data, 1);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterAbort", ready, 1);
        nRx = rxFrames.size();
        applyStimulus(8'h3C, acc2);
        waitIdle(drop);
        checkOutput("abortNoResidual", rxFrames.size(), nRx + 1);
        checkOutput("frame3C", rxFrames[nRx][8:1], 8'h3C);

        // Random offers, including offers while not ready.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 3) == 0);
            data  = 8'($urandom);
        end
        @(negedge clk);
        valid = 1'b0;
        waitIdle(drop);
        repeat (4) @(negedge clk);

        // Every completed frame must decode to the model's byte order.
        checkOutput("frameCount", rxFrames.size(), mDone.size());
        for (int i = 0; i < rxFrames.size() && i < mDone.size(); i++) begin
            checkOutput("rxByte", rxFrames[i][8:1], mDone[i]);
            checkOutput("rxStart", rxFrames[i][0], 0);
            checkOutput("rxStop", rxFrames[i][10], 1);
            checkOutput("rxParity", rxFrames[i][9], ~^rxFrames[i][8:1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
